// File: rtl/he_word_packer.sv
// Packs a stream of serial words into n_p-wide bundles for an N-write FIFO.
// A flush closes a partial bundle early; the unused upper lanes are padded with zeros.
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef N_WRITE
`define N_WRITE 4
`endif

// state   | meaning
// st_fill | collecting words into lanes 0..fill_cnt-1
// st_hold | bundle presented on bundle_o with valid_o=1, waiting for ready_i
module he_word_packer #(
    parameter int width_p = `BIT_WIDTH,
    parameter int n_p     = `N_WRITE
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [width_p-1:0]             data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic                           flush_i,
    output logic [n_p-1:0][width_p-1:0]    bundle_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [$clog2(n_p+1)-1:0]       lanes_o
);

    localparam int cnt_w   = (n_p > 1) ? $clog2(n_p) : 1;
    localparam int lanes_w = $clog2(n_p + 1);
    localparam logic [cnt_w-1:0]   last_cnt   = cnt_w'(n_p - 1);
    localparam logic [lanes_w-1:0] full_lanes = lanes_w'(n_p);

    typedef enum logic {
        st_fill = 1'b0,
        st_hold = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [cnt_w-1:0]            fill_cnt_q, fill_cnt_d;
    logic [lanes_w-1:0]          lanes_q, lanes_d;
    logic [n_p-1:0][width_p-1:0] bundle_q, bundle_d;
    logic                        in_xfer;
    logic                        out_xfer;

    // ready_i feeds ready_o combinationally so a held bundle and a new word can swap in one cycle
    assign valid_o  = (state_q == st_hold);
    assign ready_o  = (state_q == st_fill) | ((state_q == st_hold) & ready_i);
    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;
    assign bundle_o = bundle_q;
    assign lanes_o  = lanes_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= st_fill;
            fill_cnt_q <= '0;
            lanes_q    <= '0;
            bundle_q   <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            lanes_q    <= lanes_d;
            bundle_q   <= bundle_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        lanes_d    = lanes_q;
        bundle_d   = bundle_q;
        case (state_q)
            st_fill: begin
                if (in_xfer) begin
                    bundle_d[fill_cnt_q] = data_i;
                    if (fill_cnt_q == last_cnt) begin
                        state_d    = st_hold;
                        lanes_d    = full_lanes;
                        fill_cnt_d = '0;
                    end else if (flush_i) begin
                        for (int i = 0; i < n_p; i++) begin
                            if (i > int'(fill_cnt_q)) bundle_d[i] = '0;
                        end
                        state_d    = st_hold;
                        lanes_d    = lanes_w'(fill_cnt_q) + lanes_w'(1);
                        fill_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + cnt_w'(1);
                    end
                end else if (flush_i && (fill_cnt_q != '0)) begin
                    for (int i = 0; i < n_p; i++) begin
                        if (i >= int'(fill_cnt_q)) bundle_d[i] = '0;
                    end
                    state_d    = st_hold;
                    lanes_d    = lanes_w'(fill_cnt_q);
                    fill_cnt_d = '0;
                end
            end
            st_hold: begin
                // flush_i is deliberately not looked at here
                if (out_xfer) begin
                    state_d    = st_fill;
                    lanes_d    = '0;
                    fill_cnt_d = '0;
                    if (in_xfer) begin
                        bundle_d[0] = data_i;
                        if (n_p == 1) begin
                            state_d = st_hold;
                            lanes_d = full_lanes;
                        end else begin
                            fill_cnt_d = cnt_w'(1);
                        end
                    end
                end
            end
            default: state_d = st_fill;
        endcase
    end

endmodule

// File: doc/he_word_packer.md
HE_WORD_PACKER -- requirements
Module: he_word_packer

Interface
REQ-001 The block SHALL have parameter width_p, default `BIT_WIDTH, giving the bits per word.
REQ-002 The block SHALL have parameter n_p, default `N_WRITE, giving the words per output bundle (n_p >= 1).
REQ-003 The block SHALL have port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_i, input, width_p bits: serial input word.
REQ-006 The block SHALL have port valid_i, input, 1 bit: data_i is valid.
REQ-007 The block SHALL have port ready_o, output, 1 bit: the block can accept data_i this cycle.
REQ-008 The block SHALL have port flush_i, input, 1 bit: close the partial bundle and pad it.
REQ-009 The block SHALL have port bundle_o, output, [n_p-1:0][width_p-1:0]: packed bundle, lane 0 is the oldest word.
REQ-010 The block SHALL have port valid_o, output, 1 bit: bundle_o is valid and held.
REQ-011 The block SHALL have port ready_i, input, 1 bit: downstream N-write FIFO accepts the bundle (its ready_o).
REQ-012 The block SHALL have port lanes_o, output, $clog2(n_p+1) bits: count of real (non-pad) lanes in bundle_o.

Function
REQ-013 The block SHALL implement a two-state FSM: FILL (collecting words) and HOLD (bundle presented, valid_o=1).
REQ-014 An input transfer SHALL occur when valid_i & ready_o; an output transfer SHALL occur when valid_o & ready_i.
REQ-015 ready_o SHALL equal (state==FILL) | (state==HOLD & ready_i); this combinational ready_i->ready_o path is required.
REQ-016 In FILL, an accepted word SHALL be written to lane fill_cnt, and fill_cnt SHALL increment by 1.
REQ-017 When the accepted word fills lane n_p-1, the FSM SHALL move to HOLD next cycle with lanes_o=n_p and fill_cnt=0.
REQ-018 In HOLD, bundle_o and lanes_o SHALL remain stable until the output transfer.
REQ-019 On an output transfer with no simultaneous input, the FSM SHALL return to FILL with fill_cnt=0 and valid_o=0 next cycle.
REQ-020 On an output transfer with a simultaneous input transfer, the word SHALL go to lane 0, fill_cnt SHALL become 1, and the FSM SHALL enter FILL, sustaining 1 word/cycle throughput (or re-enter HOLD directly if n_p==1).
REQ-021 In FILL with flush_i=1 and (fill_cnt>0 or an input transfer this cycle), the block SHALL include any same-cycle word, zero all higher lanes, set lanes_o to the real-word count, and enter HOLD.
REQ-022 flush_i SHALL be ignored in FILL when fill_cnt==0 and no input transfer occurs (no empty bundles).
REQ-023 flush_i SHALL be ignored in HOLD and SHALL NOT be remembered.
REQ-024 Unwritten lanes of a non-flushed bundle SHALL not occur; pad lanes of a flushed bundle SHALL be exactly 0.
REQ-025 valid_o SHALL depend only on registered state (no combinational input->valid_o path).
REQ-026 fill_cnt SHALL never exceed n_p-1, and wrap to 0 only via a HOLD transition.

Reset
REQ-027 Asserting reset_n_i low SHALL immediately force state=FILL, fill_cnt=0, valid_o=0, lanes_o=0, and all bundle_o lanes=0.
REQ-028 Reset mid-fill or mid-HOLD SHALL discard the partial or held bundle without emitting it.
REQ-029 ready_o SHALL be 1 while in reset-released FILL, regardless of ready_i.

Verification (width_p=32, n_p=4)
REQ-030 Feed 1,2,3,4 on consecutive cycles with ready_i=1 -> one cycle later valid_o=1, bundle_o={4,3,2,1} (lane0=1), lanes_o=4.
REQ-031 Stream 1..8 continuously with ready_i=1 -> ready_o stays 1, bundles {1..4} then {5..8} emitted, no bubble.
REQ-032 Fill 1..4 with ready_i=0 for 3 cycles -> bundle held stable, ready_o=0, valid_i word 5 not accepted until ready_i=1, then 5 lands in lane 0.
REQ-033 Feed 7,8 then flush_i=1 alone -> bundle_o lanes={7,8,0,0}, lanes_o=2; flush with word 9 same cycle after 7,8 -> {7,8,9,0}, lanes_o=3.
REQ-034 flush_i=1 with fill_cnt=0 and valid_i=0 -> valid_o stays 0; flush_i during HOLD -> no extra bundle emitted.
REQ-035 Assert reset_n_i low after 2 words and again during HOLD -> valid_o=0, lanes_o=0 asynchronously; next bundle starts at lane 0.
